hdr_byte_serializer: RTL and testbench

HDR_BYTE_SERIALIZER -- requirements
Module: hdr_byte_serializer

---
 rtl/hdr_byte_serializer.sv | 143 ++++++++++++++
 tb/tb_hdr_byte_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_byte_serializer.sv
// hdr_byte_serializer
// Captures a left-aligned header image and streams it out one byte per
// accepted transfer, MSB-first, over a valid/ready byte interface.
// Optional feature: define CHKSUM_EN to add the chkSum output, a 16-bit
// ones-complement checksum over the bytes actually transferred.
module hdr_byte_serializer #(
  parameter int MAX_BYTES = 42,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*MAX_BYTES-1:0] hdrIn,
  input  logic [LEN_W-1:0]       hdrLen,
  input  logic                   start,
  output logic                   busy,
  output logic [7:0]             data,
  output logic                   dataValid,
  input  logic                   dataReady,
  output logic                   dataLast,
  output logic                   done
`ifdef CHKSUM_EN
  ,
  output logic [15:0]            chkSum
`endif
);

  localparam int HDR_W = 8 * MAX_BYTES;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       stateReg;
  logic [1:0]       stateNext;
  logic [HDR_W-1:0] shiftReg;
  logic [LEN_W-1:0] countReg;
  logic [LEN_W-1:0] loadCount;
  logic             startAccept;
  logic             xfer;
  logic             lastXfer;

  // A zero-length request is simply not accepted, so IDLE is kept.
  assign startAccept = (stateReg == IDLE) && start && (hdrLen != '0);
  assign loadCount   = (hdrLen > MAX_LEN) ? MAX_LEN : hdrLen;

  // All handshake outputs decode directly from registered state, so they
  // cannot change while the downstream stalls and reset clears them at once.
  assign dataValid = (stateReg == SEND);
  assign dataLast  = dataValid && (countReg == LEN_W'(1));
  assign busy      = (stateReg != IDLE);
  assign done      = (stateReg == DONE);
  assign data      = dataValid ? shiftReg[HDR_W-1 -: 8] : 8'h00;
  assign xfer      = dataValid && dataReady;
  assign lastXfer  = xfer && dataLast;

  // Next-state decode: DONE always lasts exactly one cycle.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (startAccept) stateNext = SEND;
      SEND:    if (lastXfer)    stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Header shift register and remaining-byte counter; the image is frozen
  // at capture so later hdrIn/hdrLen activity is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg <= '0;
      countReg <= '0;
    end else if (startAccept) begin
      shiftReg <= hdrIn;
      countReg <= loadCount;
    end else if (xfer) begin
      shiftReg <= {shiftReg[HDR_W-9:0], 8'h00};
      countReg <= countReg - LEN_W'(1);
    end
  end

`ifdef CHKSUM_EN
  logic [15:0] accReg;
  logic [7:0]  hiByteReg;
  logic        oddReg;
  logic        addEn;
  logic [15:0] addWord;
  logic [16:0] rawSum;
  logic [15:0] foldSum;

  // Pick the 16-bit word to add: a completed big-endian pair, or a final
  // odd byte padded with a zero low byte.
  always_comb begin
    addEn   = 1'b0;
    addWord = 16'h0000;
    if (xfer) begin
      if (oddReg) begin
        addEn   = 1'b1;
        addWord = {hiByteReg, data};
      end else if (dataLast) begin
        addEn   = 1'b1;
        addWord = {data, 8'h00};
      end
    end
  end

  // End-around carry folded on every add; the folded result never
  // carries again because both operands are at most 16'hFFFF.
  assign rawSum  = {1'b0, accReg} + {1'b0, addWord};
  assign foldSum = rawSum[15:0] + {15'd0, rawSum[16]};

  // Accumulator: cleared on an accepted start, updated per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accReg    <= 16'h0000;
      hiByteReg <= 8'h00;
      oddReg    <= 1'b0;
    end else if (startAccept) begin
      accReg    <= 16'h0000;
      hiByteReg <= 8'h00;
      oddReg    <= 1'b0;
    end else if (xfer) begin
      oddReg <= ~oddReg;
      if (!oddReg) hiByteReg <= data;
      if (addEn) accReg <= foldSum;
    end
  end

  // Final value is complete in the DONE cycle and holds until next start.
  assign chkSum = ~accReg;
`endif

endmodule

// File: tb/tb_hdr_byte_serializer.sv
// tb_hdr_byte_serializer
// Directed bench: each task drives one scenario and checks inline.
// Checksum checks are compiled in only when CHKSUM_EN is defined.
`timescale 1ns/1ps
module tb_hdr_byte_serializer;

  localparam int MB = 42;
  localparam int LW = $clog2(MB + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [8*MB-1:0] hdrIn;
  logic [LW-1:0]   hdrLen;
  logic            start;
  logic            busy;
  logic [7:0]      data;
  logic            dataValid;
  logic            dataReady;
  logic            dataLast;
  logic            done;
`ifdef CHKSUM_EN
  logic [15:0]     chkSum;
`endif

  int checks = 0;
  int passes = 0;

  // Results gathered by runHeader
  logic [7:0]  rxQ[$];
  int          lastIdx, lastCount, firstValidCyc, lastCyc, doneCyc, stallBad;
  bit          doneSeen, timedOut;
  logic        doneAfter, busyAfter;
  logic [15:0] doneChk;

  always #5 clk = ~clk;

  hdr_byte_serializer #(.MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .hdrIn(hdrIn), .hdrLen(hdrLen), .start(start),
    .busy(busy), .data(data), .dataValid(dataValid), .dataReady(dataReady),
    .dataLast(dataLast), .done(done)
`ifdef CHKSUM_EN
    , .chkSum(chkSum)
`endif
  );

  function automatic logic [8*MB-1:0] mkImg(input logic [7:0] b[$]);
    logic [8*MB-1:0] img;
    img = '0;
    for (int i = 0; i < b.size(); i++) img[8*MB-1-8*i -: 8] = b[i];
    return img;
  endfunction

  // Drives one start (assumed at posedge+1 in IDLE), scrambles the inputs
  // after capture, and records the byte stream until done or timeout.
  // pat 0: ready always high; pat 1: ready cycles 1,0,0,1.
  task automatic runHeader(input logic [8*MB-1:0] img, input int len, input int pat);
    int cyc;
    bit prevStall;
    logic [7:0] pData;
    logic pValid, pLast;
    rxQ.delete();
    lastIdx = -1; lastCount = 0; firstValidCyc = -1; lastCyc = -1; doneCyc = -1;
    stallBad = 0; doneSeen = 0; timedOut = 0; doneChk = 16'h0000;
    prevStall = 0; pData = 8'h00; pValid = 0; pLast = 0;
    hdrIn = img; hdrLen = LW'(len); start = 1'b1; dataReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hdrIn = ~img; hdrLen = LW'(5);
    cyc = 0;
    while (!doneSeen && cyc < 300) begin
      dataReady = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (prevStall && (data !== pData || dataValid !== pValid || dataLast !== pLast))
        stallBad++;
      if (dataValid && firstValidCyc < 0) firstValidCyc = cyc;
      if (done) begin
        doneSeen = 1; doneCyc = cyc;
`ifdef CHKSUM_EN
        doneChk = chkSum;
`endif
      end
      if (dataValid && dataReady) begin
        rxQ.push_back(data);
        if (dataLast) begin
          lastCount++; lastIdx = rxQ.size(); lastCyc = cyc;
        end
      end
      prevStall = dataValid && !dataReady;
      pData = data; pValid = dataValid; pLast = dataLast;
      @(posedge clk); #1;
      cyc++;
    end
    dataReady = 1'b1;
    timedOut  = !doneSeen;
    doneAfter = done;
    busyAfter = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hdrIn = '1; hdrLen = LW'(7); dataReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (dataValid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", dataValid); else passes++;
    checks++; if (dataLast !== 1'b0) $display("FAIL reset_last got=%b exp=0", dataLast); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
    checks++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else passes++;
`ifdef CHKSUM_EN
    checks++; if (chkSum !== 16'hFFFF) $display("FAIL reset_chk got=%h exp=FFFF", chkSum); else passes++;
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: outputs idle");
  endtask

  task automatic test_eth();
    logic [7:0] exp[$];
    logic [7:0] got;
    exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h11,
            8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
    runHeader(mkImg(exp), 14, 0);
    checks++; if (timedOut) $display("FAIL eth_timeout got=no_done exp=done"); else passes++;
    checks++; if (firstValidCyc !== 0) $display("FAIL eth_latency got=%0d exp=0", firstValidCyc); else passes++;
    checks++; if (rxQ.size() !== 14) $display("FAIL eth_count got=%0d exp=14", rxQ.size()); else passes++;
    for (int i = 0; i < 14; i++) begin
      got = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
      checks++; if (got !== exp[i]) $display("FAIL eth_byte%0d got=%h exp=%h", i, got, exp[i]); else passes++;
    end
    checks++; if (lastIdx !== 14 || lastCount !== 1) $display("FAIL eth_last got=idx%0d/n%0d exp=idx14/n1", lastIdx, lastCount); else passes++;
    checks++; if (doneCyc !== lastCyc + 1) $display("FAIL eth_done_cycle got=%0d exp=%0d", doneCyc, lastCyc + 1); else passes++;
    checks++; if (doneAfter !== 1'b0 || busyAfter !== 1'b0) $display("FAIL eth_done_width got=done%b/busy%b exp=0/0", doneAfter, busyAfter); else passes++;
    $display("eth: %0d bytes, last at %0d", rxQ.size(), lastIdx);
  endtask

  // Starts immediately in the cycle after the previous done.
  task automatic test_back_to_back();
    logic [7:0] exp[$];
    logic [7:0] got;
    exp = '{8'hAB, 8'hCD, 8'hEF};
    runHeader(mkImg(exp), 3, 0);
    checks++; if (timedOut || firstValidCyc !== 0) $display("FAIL b2b_accept got=first%0d exp=0", firstValidCyc); else passes++;
    checks++; if (rxQ.size() !== 3) $display("FAIL b2b_count got=%0d exp=3", rxQ.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      got = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
      checks++; if (got !== exp[i]) $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, exp[i]); else passes++;
    end
    checks++; if (lastIdx !== 3) $display("FAIL b2b_last got=%0d exp=3", lastIdx); else passes++;
`ifdef CHKSUM_EN
    // ABCD + EF00 = 19ACD -> fold 9ACE -> complement 6531
    checks++; if (doneChk !== 16'h6531) $display("FAIL b2b_chk got=%h exp=6531", doneChk); else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (chkSum !== 16'h6531) $display("FAIL b2b_chk_hold got=%h exp=6531", chkSum); else passes++;
`endif
    $display("back_to_back: %0d bytes", rxQ.size());
  endtask

  task automatic test_ip();
    logic [7:0] exp[$];
    logic [7:0] got;
    exp = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    runHeader(mkImg(exp), 20, 0);
    checks++; if (timedOut || rxQ.size() !== 20) $display("FAIL ip_count got=%0d exp=20", rxQ.size()); else passes++;
    for (int i = 0; i < 20; i++) begin
      got = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
      checks++; if (got !== exp[i]) $display("FAIL ip_byte%0d got=%h exp=%h", i, got, exp[i]); else passes++;
    end
`ifdef CHKSUM_EN
    checks++; if (doneChk !== 16'hB861) $display("FAIL ip_chk got=%h exp=B861", doneChk); else passes++;
`endif
    $display("ip: %0d bytes", rxQ.size());
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    logic [7:0] got;
    exp = '{8'h04, 8'hD2, 8'h00, 8'h35, 8'h00, 8'h1C, 8'hAB, 8'hCD};
    runHeader(mkImg(exp), 8, 1);
    checks++; if (timedOut || rxQ.size() !== 8) $display("FAIL bp_count got=%0d exp=8", rxQ.size()); else passes++;
    for (int i = 0; i < 8; i++) begin
      got = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
      checks++; if (got !== exp[i]) $display("FAIL bp_byte%0d got=%h exp=%h", i, got, exp[i]); else passes++;
    end
    checks++; if (stallBad !== 0) $display("FAIL bp_stable got=%0d_changes exp=0", stallBad); else passes++;
    checks++; if (lastIdx !== 8 || lastCount !== 1) $display("FAIL bp_last got=idx%0d/n%0d exp=idx8/n1", lastIdx, lastCount); else passes++;
    $display("backpressure: %0d bytes, stall changes %0d", rxQ.size(), stallBad);
  endtask

  task automatic test_len_one();
    logic [7:0] exp[$];
    exp = '{8'h5A, 8'h77};
    runHeader(mkImg(exp), 1, 0);
    checks++; if (timedOut || rxQ.size() !== 1) $display("FAIL one_count got=%0d exp=1", rxQ.size()); else passes++;
    checks++; if (rxQ.size() < 1 || rxQ[0] !== 8'h5A || lastIdx !== 1) $display("FAIL one_byte got=last%0d exp=5A_last1", lastIdx); else passes++;
    $display("len_one: %0d bytes", rxQ.size());
  endtask

  task automatic test_clamp();
    logic [7:0] exp[$];
    logic [7:0] got;
    for (int i = 0; i < MB; i++) exp.push_back(8'(i + 1));
    runHeader(mkImg(exp), 60, 0);
    checks++; if (timedOut || rxQ.size() !== MB) $display("FAIL clamp_count got=%0d exp=%0d", rxQ.size(), MB); else passes++;
    for (int i = 0; i < MB; i++) begin
      got = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
      checks++; if (got !== 8'(i + 1)) $display("FAIL clamp_byte%0d got=%h exp=%h", i, got, 8'(i + 1)); else passes++;
    end
    checks++; if (lastIdx !== MB) $display("FAIL clamp_last got=%0d exp=%0d", lastIdx, MB); else passes++;
    $display("clamp: %0d bytes, last at %0d", rxQ.size(), lastIdx);
  endtask

  // Zero-length start, then start during SEND, then reset at byte 5 of 22.
  task automatic test_reset_abort();
    logic [7:0] exp[$];
    int cyc, badValid, badDone;
    bit found;
    for (int i = 0; i < 22; i++) exp.push_back(8'(8'hA0 + i));
    hdrIn = mkImg(exp); hdrLen = LW'(0); start = 1'b1; dataReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || dataValid !== 1'b0) $display("FAIL zero_len got=busy%b/valid%b exp=0/0", busy, dataValid); else passes++;
    @(posedge clk); #1;
    checks++; if (dataValid !== 1'b0 || done !== 1'b0) $display("FAIL zero_len2 got=valid%b/done%b exp=0/0", dataValid, done); else passes++;

    rxQ.delete();
    hdrLen = LW'(22); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; found = 0;
    while (cyc < 40 && !found) begin
      if (cyc == 1) begin start = 1'b1; hdrLen = LW'(2); hdrIn = '0; end
      else start = 1'b0;
      if (dataValid && rxQ.size() == 4) found = 1;
      else begin
        if (dataValid && dataReady) rxQ.push_back(data);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    checks++; if (!found) $display("FAIL abort_reach got=no_byte5 exp=byte5"); else passes++;
    checks++; if (rxQ.size() !== 4 || rxQ[0] !== 8'hA0 || rxQ[3] !== 8'hA3) $display("FAIL abort_prefix got=n%0d exp=A0..A3", rxQ.size()); else passes++;
    checks++; if (data !== 8'hA4) $display("FAIL abort_byte5 got=%h exp=A4", data); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (dataValid !== 1'b0 || busy !== 1'b0 || dataLast !== 1'b0) $display("FAIL abort_async got=valid%b/busy%b/last%b exp=0/0/0", dataValid, busy, dataLast); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    badValid = 0; badDone = 0;
    for (int i = 0; i < 6; i++) begin
      if (dataValid || busy) badValid++;
      if (done) badDone++;
      @(posedge clk); #1;
    end
    checks++; if (badDone !== 0) $display("FAIL abort_no_done got=%0d exp=0", badDone); else passes++;
    checks++; if (badValid !== 0) $display("FAIL abort_idle got=%0d exp=0", badValid); else passes++;
    $display("reset_abort: prefix %0d bytes before reset", rxQ.size());
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hdrIn = '0; hdrLen = '0; dataReady = 1'b1;
    test_reset();
    test_eth();
    test_back_to_back();
    test_ip();
    test_backpressure();
    test_len_one();
    test_clamp();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
